// File: rtl/adder16_mp_ctrl.sv
// Multi-precision add/subtract sequencer: pushes WORDS x 16-bit operands through one
// 16-bit add slice per clock, chaining the carry from the least- to the most-significant word.
module adder16_mp_ctrl #(
  parameter int WORDS  = 4,
  parameter int WORD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [16*WORDS-1:0] sum,
  output logic                carry_out,
  output logic                overflow
);

  localparam int N     = 16 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int MSB   = WORD_W - 1;

  // Handshake: start is sampled only while idle; after acceptance busy stays high for
  // exactly WORDS cycles, and done pulses for one cycle once the full result is in sum.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic             sub_q;
  logic             carry_q;

  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_word;
  logic [WORD_W:0]   slice;
  logic              last_word;
  logic              slice_ovf;

  // One slice of the wide operation; b is inverted for subtract and the +1 comes in
  // through carry_q, which is seeded with sub on acceptance.
  always_comb begin
    a_word    = a_q[idx*WORD_W +: WORD_W];
    b_word    = b_q[idx*WORD_W +: WORD_W] ^ {WORD_W{sub_q}};
    slice     = {1'b0, a_word} + {1'b0, b_word} + {{WORD_W{1'b0}}, carry_q};
    last_word = (idx == IDX_W'(WORDS - 1));
    slice_ovf = (a_word[MSB] == b_word[MSB]) && (slice[MSB] != a_word[MSB]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            carry_q <= sub;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum[idx*WORD_W +: WORD_W] <= slice[WORD_W-1:0];
          carry_q                   <= slice[WORD_W];
          if (last_word) begin
            // Only the most-significant slice defines the full-width flags.
            carry_out <= slice[WORD_W];
            overflow  <= slice_ovf;
            busy      <= 1'b0;
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder16_mp_ctrl.sv
// Bench for adder16_mp_ctrl: a WORDS=4 and a WORDS=1 instance, a vector table of
// directed and random operations, and hand-written start-glitch and mid-run reset sequences.
module tb_adder16_mp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start4, sub4;
  logic [63:0] a4, b4, sum4;
  logic        busy4, done4, cout4, ovf4;

  logic        start1, sub1;
  logic [15:0] a1, b1, sum1;
  logic        busy1, done1, cout1, ovf1;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] prev_sum4;
  logic [15:0] prev_sum1;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] e_sum;
    logic        e_c;
    logic        e_v;
  } vec_t;

  typedef struct {
    logic [63:0] sum;
    logic        c;
    logic        v;
  } res_t;

  vec_t tbl[14];

  adder16_mp_ctrl #(.WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(cout4), .overflow(ovf4)
  );

  adder16_mp_ctrl #(.WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1), .overflow(ovf1)
  );

  always #5 clk = ~clk;

  // Full-width reference: subtraction is a + ~b + 1; signed overflow when both
  // addends share a sign that the result does not.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input int w);
    logic [63:0] m, bb;
    logic [64:0] r;
    res_t res;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    bb = (s ? ~b : b) & m;
    r  = {1'b0, a & m} + {1'b0, bb} + {64'd0, s};
    res.sum = r[63:0] & m;
    res.c   = r[w];
    res.v   = (a[w-1] == bb[w-1]) && (res.sum[w-1] != a[w-1]);
    return res;
  endfunction

  function automatic logic [15:0] pick_word();
    case ($urandom_range(0, 4))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one WORDS=4 operation and checks busy/done timing cycle by cycle. A nonzero
  // glitch_n pulses start with different operands at that negedge after acceptance.
  task automatic run_op4(input vec_t v, input int glitch_n);
    @(negedge clk);
    start4 = 1'b1; a4 = v.a; b4 = v.b; sub4 = v.sub;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start4 = 1'b0;
        a4 = {$urandom(), $urandom()}; b4 = {$urandom(), $urandom()}; sub4 = ~v.sub;
      end
      if (glitch_n != 0 && n == glitch_n) begin
        start4 = 1'b1; a4 = ~v.a; b4 = v.b + 64'd3;
      end else if (glitch_n != 0 && n == glitch_n + 1) begin
        start4 = 1'b0;
      end
      chk("busy4", 64'(busy4), 64'(n <= 4));
      chk("done4", 64'(done4), 64'(n == 6));
      if (n == 1) chk("sum4_hold_before", sum4, prev_sum4);
      if (n == 6) begin
        chk("sum4", sum4, v.e_sum);
        chk("carry4", 64'(cout4), 64'(v.e_c));
        chk("ovf4", 64'(ovf4), 64'(v.e_v));
      end
      if (n == 7) chk("sum4_hold_after", sum4, v.e_sum);
    end
    start4 = 1'b0;
    prev_sum4 = v.e_sum;
  endtask

  task automatic run_op1(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] e_sum, input logic e_c, input logic e_v);
    @(negedge clk);
    start1 = 1'b1; a1 = a; b1 = b; sub1 = s;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start1 = 1'b0; a1 = 16'($urandom()); b1 = 16'($urandom());
      end
      chk("busy1", 64'(busy1), 64'(n == 1));
      chk("done1", 64'(done1), 64'(n == 3));
      if (n == 1) chk("sum1_hold_before", 64'(sum1), 64'(prev_sum1));
      if (n == 3) begin
        chk("sum1", 64'(sum1), 64'(e_sum));
        chk("carry1", 64'(cout1), 64'(e_c));
        chk("ovf1", 64'(ovf1), 64'(e_v));
      end
    end
    prev_sum1 = e_sum;
  endtask

  task automatic reset_mid4(input vec_t v);
    @(negedge clk);
    start4 = 1'b1; a4 = v.a; b4 = v.b; sub4 = v.sub;
    @(negedge clk);
    start4 = 1'b0;
    chk("busy4_pre_reset", 64'(busy4), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    start4 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start4 = 1'b0;
    chk("busy4_after_reset", 64'(busy4), 64'd0);
    chk("sum4_after_reset", sum4, 64'd0);
    chk("done4_after_reset", 64'(done4), 64'd0);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("no_done_after_reset", 64'(done4 | busy4), 64'd0);
    end
    prev_sum4 = 64'd0;
    prev_sum1 = 16'd0;
  endtask

  initial begin
    res_t r;
    vec_t v;
    rst_n = 1'b0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    prev_sum4 = '0;
    prev_sum1 = '0;

    tbl[0] = '{a: 64'h0000_0000_0000_FFFF, b: 64'h1, sub: 1'b0,
               e_sum: 64'h0000_0000_0001_0000, e_c: 1'b0, e_v: 1'b0};
    tbl[1] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'h1, sub: 1'b0,
               e_sum: 64'h0, e_c: 1'b1, e_v: 1'b0};
    tbl[2] = '{a: 64'h0000_0001_0000_0000, b: 64'h1, sub: 1'b1,
               e_sum: 64'h0000_0000_FFFF_FFFF, e_c: 1'b1, e_v: 1'b0};
    tbl[3] = '{a: 64'h0, b: 64'h1, sub: 1'b1,
               e_sum: 64'hFFFF_FFFF_FFFF_FFFF, e_c: 1'b0, e_v: 1'b0};
    tbl[4] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'h1, sub: 1'b0,
               e_sum: 64'h8000_0000_0000_0000, e_c: 1'b0, e_v: 1'b1};
    tbl[5] = '{a: 64'h8000_0000_0000_0000, b: 64'h1, sub: 1'b1,
               e_sum: 64'h7FFF_FFFF_FFFF_FFFF, e_c: 1'b1, e_v: 1'b1};
    for (int i = 6; i < 14; i++) begin
      tbl[i].a   = {pick_word(), pick_word(), pick_word(), pick_word()};
      tbl[i].b   = {pick_word(), pick_word(), pick_word(), pick_word()};
      tbl[i].sub = 1'($urandom_range(0, 1));
      r = model(tbl[i].a, tbl[i].b, tbl[i].sub, 64);
      tbl[i].e_sum = r.sum;
      tbl[i].e_c   = r.c;
      tbl[i].e_v   = r.v;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy4", 64'(busy4), 64'd0);
    chk("reset_done4", 64'(done4), 64'd0);
    chk("reset_sum4", sum4, 64'd0);
    chk("reset_flags4", {62'd0, cout4, ovf4}, 64'd0);
    chk("reset_sum1", 64'(sum1), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_op4(tbl[i], 0);

    // Start pulses in RUN and in DONE are dropped.
    v = tbl[1];
    run_op4(v, 2);
    run_op4(tbl[4], 5);

    reset_mid4(tbl[0]);
    run_op4(tbl[2], 0);

    run_op1(16'h8FFF, 16'h8000, 1'b0, 16'h0FFF, 1'b1, 1'b1);
    run_op1(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] ra, rb;
      logic        rs;
      ra = pick_word();
      rb = pick_word();
      rs = 1'($urandom_range(0, 1));
      r  = model({48'd0, ra}, {48'd0, rb}, rs, 16);
      run_op1(ra, rb, rs, r.sum[15:0], r.c, r.v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
